// File: rtl/cpu_pkg.sv
// Shared CPU front-end types: machine width, instruction size and the
// fetch-queue entry that pairs an instruction word with its PC.
package cpu_pkg;

  localparam int unsigned XLEN        = 32;
  localparam int unsigned INSTR_BYTES = 4;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_if.sv
// Fetch-stage bundle: instruction-memory request/response, decode handshake
// and redirect. master = fetch unit side, slave = memory/decode/branch side.
interface fetch_if #(
  parameter int unsigned XLEN = 32
);

  logic            mem_req_valid;
  logic            mem_req_ready;
  logic [XLEN-1:0] mem_req_addr;
  logic            mem_resp_valid;
  logic [XLEN-1:0] mem_resp_data;
  logic            dec_valid;
  logic [XLEN-1:0] dec_data;
  logic [XLEN-1:0] dec_pc;
  logic            dec_ready;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_target;

  modport master (
    output mem_req_valid, mem_req_addr, dec_valid, dec_data, dec_pc,
    input  mem_req_ready, mem_resp_valid, mem_resp_data, dec_ready,
           redirect_valid, redirect_target
  );

  modport slave (
    input  mem_req_valid, mem_req_addr, dec_valid, dec_data, dec_pc,
    output mem_req_ready, mem_resp_valid, mem_resp_data, dec_ready,
           redirect_valid, redirect_target
  );

endinterface

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush; head is shown combinationally from storage.
// Storage resets to zero so the head reads as zero straight out of reset.
module fetch_fifo #(
  parameter type         T     = logic [31:0],
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  T                           push_data,
  output T                           head,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  T               mem [DEPTH];
  logic [PW-1:0]  rd_ptr;
  logic [PW-1:0]  wr_ptr;

  // Explicit wrap keeps non-power-of-2 depths (e.g. MAX_OUT=3) correct.
  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
    return (32'(p) == DEPTH - 1) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wrap_inc(wr_ptr);
      end
      if (pop) rd_ptr <= wrap_inc(rd_ptr);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  assert property (@(posedge clk) disable iff (!rst_n)
    !(push && full && !pop && !flush));

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, keeps up to MAX_OUT in-order
// memory requests in flight and buffers PC-tagged responses for decode.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int unsigned     XLEN     = cpu_pkg::XLEN,
  parameter int unsigned     DEPTH    = 4,
  parameter int unsigned     MAX_OUT  = 2,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic     clk,
  input  logic     rst_n,
  fetch_if.master  bus
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned OW = $clog2(MAX_OUT + 1);

  logic [XLEN-1:0] pc;
  logic [OW-1:0]   outstanding;
  logic [OW-1:0]   outstanding_next;
  logic [OW-1:0]   drop;

  logic            accept;
  logic            resp;
  logic            credit_ok;

  logic            q_push;
  logic            q_pop;
  logic            q_full;
  logic            q_empty;
  logic [CW-1:0]   q_count;
  fetch_entry_t    q_in;
  fetch_entry_t    q_head;

  logic            if_pop;
  logic            if_full;
  logic            if_empty;
  logic [OW-1:0]   if_count;
  logic [XLEN-1:0] if_head;

  assign accept           = bus.mem_req_valid && bus.mem_req_ready;
  assign resp             = bus.mem_resp_valid;
  assign outstanding_next = outstanding + OW'(accept) - OW'(resp);

  // Slots already promised to in-flight, non-dropped requests count as used.
  assign credit_ok = (32'(q_count) + 32'(outstanding) - 32'(drop)) < DEPTH;

  assign bus.mem_req_valid = rst_n && !bus.redirect_valid
                             && (32'(outstanding) < MAX_OUT) && credit_ok;
  assign bus.mem_req_addr  = pc;

  // Responses to requests issued before a redirect own no in-flight PC entry.
  assign if_pop = resp && (drop == '0);
  assign q_push = if_pop && !bus.redirect_valid;
  assign q_pop  = bus.dec_valid && bus.dec_ready && !bus.redirect_valid;
  assign q_in   = '{pc: if_head, instr: bus.mem_resp_data};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      outstanding <= '0;
      drop        <= '0;
    end else begin
      outstanding <= outstanding_next;
      if (bus.redirect_valid) begin
        pc   <= {bus.redirect_target[XLEN-1:2], 2'b00};
        drop <= outstanding_next;
      end else begin
        if (accept) pc <= pc + XLEN'(INSTR_BYTES);
        if (resp && (drop != '0)) drop <= drop - 1'b1;
      end
    end
  end

  fetch_fifo #(
    .T     (logic [XLEN-1:0]),
    .DEPTH (MAX_OUT)
  ) u_inflight (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (accept),
    .pop       (if_pop),
    .flush     (bus.redirect_valid),
    .push_data (pc),
    .head      (if_head),
    .full      (if_full),
    .empty     (if_empty),
    .count     (if_count)
  );

  fetch_fifo #(
    .T     (fetch_entry_t),
    .DEPTH (DEPTH)
  ) u_queue (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (q_push),
    .pop       (q_pop),
    .flush     (bus.redirect_valid),
    .push_data (q_in),
    .head      (q_head),
    .full      (q_full),
    .empty     (q_empty),
    .count     (q_count)
  );

  assign bus.dec_valid = !q_empty;
  assign bus.dec_data  = q_head.instr;
  assign bus.dec_pc    = q_head.pc;

  assert property (@(posedge clk) disable iff (!rst_n) !(resp && outstanding == '0));
  assert property (@(posedge clk) disable iff (!rst_n) drop <= outstanding);
  assert property (@(posedge clk) disable iff (!rst_n)
    32'(if_count) == 32'(outstanding) - 32'(drop));
  assert property (@(posedge clk) disable iff (!rst_n) !(accept && if_full));
  assert property (@(posedge clk) disable iff (!rst_n) !(if_pop && if_empty));
  assert property (@(posedge clk) disable iff (!rst_n) !(q_push && q_full && !q_pop));

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: in-order memory model, expected-instruction
// scoreboard filled at request accept and drained at decode handshake.
module tb_fetch_unit;
  import cpu_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  logic rst2_n;
  always #5 clk = ~clk;

  fetch_if #(.XLEN(32)) b  ();
  fetch_if #(.XLEN(32)) b2 ();

  fetch_unit #(.XLEN(32), .DEPTH(4), .MAX_OUT(2), .RESET_PC(32'h0000_0000))
    u1 (.clk(clk), .rst_n(rst_n), .bus(b));

  fetch_unit #(.XLEN(32), .DEPTH(4), .MAX_OUT(2), .RESET_PC(32'hFFFF_FFF8))
    u2 (.clk(clk), .rst_n(rst2_n), .bus(b2));

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  int           n_cmp = 0;
  int           n_err = 0;
  int           cyc = 0;
  int           acc_cnt = 0;
  int           dec_cnt = 0;
  mreq_t        mem_q[$];
  fetch_entry_t exp_q[$];
  logic [31:0]  exp_pc;
  bit           mem_hold;

  function automatic logic [31:0] mdata(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h0BAD_F00D;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle for u1; called just after a falling edge with inputs set.
  task automatic cycle();
    bit resp_now;
    fetch_entry_t e;
    resp_now = (mem_q.size() > 0) && (mem_q[0].due <= cyc) && !mem_hold;
    b.mem_resp_valid = resp_now;
    b.mem_resp_data  = resp_now ? mdata(mem_q[0].addr) : 32'h0;
    #1;
    if (b.mem_req_valid && b.mem_req_ready) begin
      chk("req_addr", b.mem_req_addr, exp_pc);
      mem_q.push_back('{addr: b.mem_req_addr, due: cyc + 1});
      exp_q.push_back('{pc: exp_pc, instr: mdata(exp_pc)});
      exp_pc += 32'd4;
      acc_cnt++;
    end
    if (b.dec_valid && b.dec_ready && !b.redirect_valid) begin
      n_cmp++;
      assert (exp_q.size() > 0) else begin
        n_err++;
        $error("FAIL dec_extra: observed pc=%h expected no instruction", b.dec_pc);
      end
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("dec_pc", b.dec_pc, e.pc);
        chk("dec_data", b.dec_data, e.instr);
      end
      dec_cnt++;
    end
    if (b.redirect_valid) begin
      exp_q.delete();
      exp_pc = b.redirect_target & ~32'h3;
    end
    if (resp_now) void'(mem_q.pop_front());
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic redirect(input logic [31:0] target);
    b.redirect_valid  = 1'b1;
    b.redirect_target = target;
    cycle();
    b.redirect_valid  = 1'b0;
  endtask

  task automatic drain(input string tag);
    b.mem_req_ready = 1'b0;
    b.dec_ready     = 1'b1;
    mem_hold        = 1'b0;
    repeat (6) cycle();
    chk({tag, "_sb_empty"}, 32'(exp_q.size()), 32'd0);
    chk({tag, "_dec_valid"}, 32'(b.dec_valid), 32'd0);
  endtask

  initial begin
    int a0;
    int d0;
    rst_n = 1'b0;
    rst2_n = 1'b0;
    mem_hold = 1'b0;
    exp_pc = 32'h0;
    b.mem_req_ready = 1'b0;  b.mem_resp_valid = 1'b0;  b.mem_resp_data = '0;
    b.dec_ready = 1'b0;      b.redirect_valid = 1'b0;  b.redirect_target = '0;
    b2.mem_req_ready = 1'b0; b2.mem_resp_valid = 1'b0; b2.mem_resp_data = '0;
    b2.dec_ready = 1'b0;     b2.redirect_valid = 1'b0; b2.redirect_target = '0;

    #2;
    chk("rst_req_valid", 32'(b.mem_req_valid), 32'd0);
    chk("rst_dec_valid", 32'(b.dec_valid), 32'd0);
    chk("rst_dec_data", b.dec_data, 32'h0);
    chk("rst_dec_pc", b.dec_pc, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: streaming, one instruction per cycle after two cycles of latency
    b.mem_req_ready = 1'b1;
    b.dec_ready     = 1'b1;
    d0 = dec_cnt;
    repeat (10) cycle();
    chk("t1_rate", 32'(dec_cnt - d0), 32'd8);
    drain("t1");

    // 2: decode stalled, credits cap accepts at DEPTH
    redirect(32'h0);
    b.dec_ready     = 1'b0;
    b.mem_req_ready = 1'b1;
    a0 = acc_cnt;
    repeat (8) cycle();
    chk("t2_accepts", 32'(acc_cnt - a0), 32'd4);
    chk("t2_req_blocked", 32'(b.mem_req_valid), 32'd0);
    chk("t2_dec_valid", 32'(b.dec_valid), 32'd1);
    b.mem_req_ready = 1'b0;
    b.dec_ready     = 1'b1;
    d0 = dec_cnt;
    repeat (6) cycle();
    chk("t2_drained", 32'(dec_cnt - d0), 32'd4);

    // 3: memory not ready, request held stable
    redirect(32'h0);
    b.mem_req_ready = 1'b0;
    repeat (5) begin
      #1;
      chk("t3_valid", 32'(b.mem_req_valid), 32'd1);
      chk("t3_addr", b.mem_req_addr, 32'h0);
      cycle();
    end
    b.mem_req_ready = 1'b1;
    a0 = acc_cnt;
    cycle();
    chk("t3_accept", 32'(acc_cnt - a0), 32'd1);
    drain("t3");

    // 4: redirect with two requests in flight
    redirect(32'h10);
    b.mem_req_ready = 1'b1;
    mem_hold = 1'b1;
    repeat (2) cycle();
    #1;
    chk("t4_max_out", 32'(b.mem_req_valid), 32'd0);
    redirect(32'h103);
    mem_hold = 1'b0;
    a0 = acc_cnt;
    d0 = dec_cnt;
    repeat (8) cycle();
    chk("t4_accepts", 32'(acc_cnt - a0), 32'd7);
    chk("t4_decoded", 32'(dec_cnt - d0), 32'd5);
    drain("t4");

    // 5: redirect coinciding with a response
    redirect(32'h200);
    b.mem_req_ready = 1'b1;
    mem_hold = 1'b1;
    repeat (2) cycle();
    mem_hold = 1'b0;
    redirect(32'h300);
    chk("t5_drop_1", 32'(u1.drop), 32'd1);
    chk("t5_dec_valid_a", 32'(b.dec_valid), 32'd0);
    b.mem_req_ready = 1'b0;
    cycle();
    chk("t5_drop_0", 32'(u1.drop), 32'd0);
    chk("t5_outstanding", 32'(u1.outstanding), 32'd0);
    chk("t5_dec_valid_b", 32'(b.dec_valid), 32'd0);
    b.mem_req_ready = 1'b1;
    d0 = dec_cnt;
    repeat (5) cycle();
    chk("t5_restart", 32'(dec_cnt - d0), 32'd3);
    drain("t5");

    // 6: PC wrap from RESET_PC near the top, then async reset mid-burst
    rst2_n = 1'b1;
    b2.mem_req_ready = 1'b1;
    #1;
    chk("t6_valid", 32'(b2.mem_req_valid), 32'd1);
    chk("t6_addr0", b2.mem_req_addr, 32'hFFFF_FFF8);
    @(negedge clk);
    b2.mem_resp_valid = 1'b1;
    b2.mem_resp_data  = mdata(32'hFFFF_FFF8);
    #1;
    chk("t6_addr1", b2.mem_req_addr, 32'hFFFF_FFFC);
    @(negedge clk);
    b2.mem_resp_data  = mdata(32'hFFFF_FFFC);
    #1;
    chk("t6_addr2", b2.mem_req_addr, 32'h0000_0000);
    chk("t6_dec_valid", 32'(b2.dec_valid), 32'd1);
    chk("t6_dec_pc", b2.dec_pc, 32'hFFFF_FFF8);
    chk("t6_dec_data", b2.dec_data, mdata(32'hFFFF_FFF8));
    @(negedge clk);
    b2.mem_resp_data  = mdata(32'h0000_0000);
    #1;
    chk("t6_addr3", b2.mem_req_addr, 32'h0000_0004);
    #1;
    rst2_n = 1'b0;
    #1;
    chk("t6_rst_dec_valid", 32'(b2.dec_valid), 32'd0);
    chk("t6_rst_req_valid", 32'(b2.mem_req_valid), 32'd0);
    chk("t6_rst_dec_pc", b2.dec_pc, 32'h0);
    b2.mem_resp_valid = 1'b0;
    b2.mem_req_ready  = 1'b0;
    @(negedge clk);

    chk("final_sb_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
